// File: rtl/emulib_dmamodel_inflight_ctrl_if.sv
// Handshake bundle around the DMA in-flight gate: host-side and issue-queue-side
// AR/AW/W valid/ready pairs, plus the observed R and B handshakes.
interface emulib_dmamodel_inflight_ctrl_if #(
  parameter int LEN_WIDTH = 8
);
  logic                 s_arvalid;
  logic                 s_arready;
  logic                 s_awvalid;
  logic                 s_awready;
  logic [LEN_WIDTH-1:0] s_awlen;
  logic                 s_wvalid;
  logic                 s_wready;
  logic                 s_wlast;
  logic                 m_arvalid;
  logic                 m_arready;
  logic                 m_awvalid;
  logic                 m_awready;
  logic                 m_wvalid;
  logic                 m_wready;
  logic                 rvalid;
  logic                 rready;
  logic                 rlast;
  logic                 bvalid;
  logic                 bready;

  // Environment view: host and issue queues around the gate.
  modport master (
    output s_arvalid, s_awvalid, s_awlen, s_wvalid, s_wlast,
           m_arready, m_awready, m_wready,
           rvalid, rready, rlast, bvalid, bready,
    input  s_arready, s_awready, s_wready, m_arvalid, m_awvalid, m_wvalid
  );

  // Gate view.
  modport slave (
    input  s_arvalid, s_awvalid, s_awlen, s_wvalid, s_wlast,
           m_arready, m_awready, m_wready,
           rvalid, rready, rlast, bvalid, bready,
    output s_arready, s_awready, s_wready, m_arvalid, m_awvalid, m_wvalid
  );
endinterface

// File: rtl/emulib_dmamodel_inflight_ctrl.sv
// DMA in-flight limiter: caps outstanding AR/AW bursts, holds W until AW is accepted,
// checks WLAST against AWLEN and reports drain. Optional no-progress timeout: DMA_INFLIGHT_TIMEOUT_EN.
module emulib_dmamodel_inflight_ctrl #(
  parameter int MAX_R_INFLIGHT = 4,
  parameter int MAX_W_INFLIGHT = 4,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                mdl_clk,
  input  logic                                mdl_rst,
  emulib_dmamodel_inflight_ctrl_if.slave      bus,
  input  logic                                drain_req,
  output logic                                drained,
  output logic [$clog2(MAX_R_INFLIGHT+1)-1:0] r_inflight,
  output logic [$clog2(MAX_W_INFLIGHT+1)-1:0] w_inflight,
  output logic                                err_wlast,
  output logic                                err_unexp,
  output logic                                err_timeout
);
  localparam int RC_W  = $clog2(MAX_R_INFLIGHT+1);
  localparam int WC_W  = $clog2(MAX_W_INFLIGHT+1);
  localparam int WB_W  = LEN_WIDTH + $clog2(MAX_W_INFLIGHT) + 1;
  localparam int PTR_W = (MAX_W_INFLIGHT > 1) ? $clog2(MAX_W_INFLIGHT) : 1;

  logic [RC_W-1:0]      r_rcnt;
  logic [WC_W-1:0]      r_wcnt;
  logic [WB_W-1:0]      r_wbeats;
  logic [LEN_WIDTH-1:0] r_len_q [MAX_W_INFLIGHT];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [WC_W-1:0]      r_fcnt;
  logic [LEN_WIDTH-1:0] r_beat_idx;
  logic                 r_drained;
  logic                 r_err_wlast;
  logic                 r_err_unexp;

  logic w_allow_ar, w_allow_aw, w_allow_w;
  logic w_ar_hs, w_aw_hs, w_w_hs, w_rlast_hs, w_b_hs;
  logic w_fifo_nempty, w_last_beat, w_push, w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_W_INFLIGHT-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_allow_ar = (r_rcnt < RC_W'(MAX_R_INFLIGHT)) && !drain_req;
  assign w_allow_aw = (r_wcnt < WC_W'(MAX_W_INFLIGHT)) && !drain_req;
  assign w_allow_w  = (r_wbeats != '0);

  assign bus.m_arvalid = bus.s_arvalid && w_allow_ar;
  assign bus.s_arready = bus.m_arready && w_allow_ar;
  assign bus.m_awvalid = bus.s_awvalid && w_allow_aw;
  assign bus.s_awready = bus.m_awready && w_allow_aw;
  assign bus.m_wvalid  = bus.s_wvalid  && w_allow_w;
  assign bus.s_wready  = bus.m_wready  && w_allow_w;

  assign w_ar_hs    = bus.s_arvalid && bus.s_arready;
  assign w_aw_hs    = bus.s_awvalid && bus.s_awready;
  assign w_w_hs     = bus.s_wvalid  && bus.s_wready;
  assign w_rlast_hs = bus.rvalid && bus.rready && bus.rlast;
  assign w_b_hs     = bus.bvalid && bus.bready;

  // Head of the AWLEN FIFO describes the burst the current W beats belong to.
  assign w_fifo_nempty = (r_fcnt != '0);
  assign w_last_beat   = (r_beat_idx == r_len_q[r_rd_ptr]);
  assign w_pop         = w_w_hs && w_fifo_nempty && w_last_beat;
  assign w_push        = w_aw_hs && ((r_fcnt != WC_W'(MAX_W_INFLIGHT)) || w_pop);

  always_ff @(posedge mdl_clk or posedge mdl_rst) begin
    if (mdl_rst) begin
      r_rcnt      <= '0;
      r_wcnt      <= '0;
      r_wbeats    <= '0;
      r_drained   <= 1'b0;
      r_err_unexp <= 1'b0;
    end else begin
      if (w_ar_hs && !w_rlast_hs) begin
        r_rcnt <= r_rcnt + RC_W'(1);
      end else if (!w_ar_hs && w_rlast_hs) begin
        if (r_rcnt == '0) r_err_unexp <= 1'b1;
        else              r_rcnt      <= r_rcnt - RC_W'(1);
      end

      if (w_aw_hs && !w_b_hs) begin
        r_wcnt <= r_wcnt + WC_W'(1);
      end else if (!w_aw_hs && w_b_hs) begin
        if (r_wcnt == '0) r_err_unexp <= 1'b1;
        else              r_wcnt      <= r_wcnt - WC_W'(1);
      end

      if (w_aw_hs && w_w_hs)  r_wbeats <= r_wbeats + WB_W'(bus.s_awlen);
      else if (w_aw_hs)       r_wbeats <= r_wbeats + WB_W'(bus.s_awlen) + WB_W'(1);
      else if (w_w_hs)        r_wbeats <= r_wbeats - WB_W'(1);

      r_drained <= drain_req && (r_rcnt == '0) && (r_wcnt == '0) && (r_wbeats == '0);
    end
  end

  always_ff @(posedge mdl_clk or posedge mdl_rst) begin
    if (mdl_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fcnt      <= '0;
      r_beat_idx  <= '0;
      r_err_wlast <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_fcnt <= r_fcnt + WC_W'(1);
      else if (w_pop && !w_push) r_fcnt <= r_fcnt - WC_W'(1);

      if (w_pop)                          r_beat_idx <= '0;
      else if (w_w_hs && w_fifo_nempty)   r_beat_idx <= r_beat_idx + LEN_WIDTH'(1);

      // Mismatched beats are still forwarded; only the flag records them.
      if (w_w_hs && w_fifo_nempty && (bus.s_wlast != w_last_beat)) r_err_wlast <= 1'b1;
    end
  end

  always_ff @(posedge mdl_clk) begin
    if (w_push) r_len_q[r_wr_ptr] <= bus.s_awlen;
  end

`ifdef DMA_INFLIGHT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] r_tmo;
  logic             r_err_tmo;
  logic             w_busy;
  logic             w_progress;

  assign w_busy     = (r_rcnt != '0) || (r_wcnt != '0) || (r_wbeats != '0);
  assign w_progress = (bus.rvalid && bus.rready) || w_b_hs || w_w_hs;

  // Flag on the edge where the count reaches TIMEOUT_CYCLES-1.
  always_ff @(posedge mdl_clk or posedge mdl_rst) begin
    if (mdl_rst) begin
      r_tmo     <= '0;
      r_err_tmo <= 1'b0;
    end else if (!w_busy || w_progress) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TMO_W'(1);
      if (r_tmo == TMO_W'(TIMEOUT_CYCLES-2)) r_err_tmo <= 1'b1;
    end
  end

  assign err_timeout = r_err_tmo;
`else
  assign err_timeout = 1'b0;
`endif

  assign drained    = r_drained;
  assign r_inflight = r_rcnt;
  assign w_inflight = r_wcnt;
  assign err_wlast  = r_err_wlast;
  assign err_unexp  = r_err_unexp;
endmodule

// File: tb/tb_emulib_dmamodel_inflight_ctrl.sv
// Bench for emulib_dmamodel_inflight_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based burst model.
module tb_emulib_dmamodel_inflight_ctrl;
  localparam int MAX_R = 2;
  localparam int MAX_W = 2;
  localparam int LW    = 8;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       drain_req = 1'b0;
  logic       drained, err_wlast, err_unexp, err_timeout;
  logic [1:0] r_inflight, w_inflight;

  int n_chk = 0;
  int n_err = 0;

  emulib_dmamodel_inflight_ctrl_if #(.LEN_WIDTH(LW)) bus();

  emulib_dmamodel_inflight_ctrl #(
    .MAX_R_INFLIGHT(MAX_R), .MAX_W_INFLIGHT(MAX_W),
    .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .mdl_clk(clk), .mdl_rst(rst), .bus(bus), .drain_req(drain_req),
    .drained(drained), .r_inflight(r_inflight), .w_inflight(w_inflight),
    .err_wlast(err_wlast), .err_unexp(err_unexp), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: outstanding burst counts, and one queue entry of remaining beats per accepted AW.
  int m_rc = 0, m_wc = 0, m_tm = 0;
  int m_q[$];
  bit m_ew = 0, m_eu = 0, m_et = 0, m_dr = 0;

  function automatic int m_wb();
    int s = 0;
    foreach (m_q[i]) s += m_q[i];
    return s;
  endfunction

  task automatic model_step();
    bit ar_hs, aw_hs, w_hs, rl, bh, busy, prog;
    int wb;
    wb    = m_wb();
    ar_hs = bus.s_arvalid && bus.m_arready && (m_rc < MAX_R) && !drain_req;
    aw_hs = bus.s_awvalid && bus.m_awready && (m_wc < MAX_W) && !drain_req;
    w_hs  = bus.s_wvalid && bus.m_wready && (wb != 0);
    rl    = bus.rvalid && bus.rready && bus.rlast;
    bh    = bus.bvalid && bus.bready;
    busy  = (m_rc != 0) || (m_wc != 0) || (wb != 0);
    prog  = (bus.rvalid && bus.rready) || bh || w_hs;
    m_dr  = drain_req && !busy;
`ifdef DMA_INFLIGHT_TIMEOUT_EN
    if (busy && !prog) begin
      m_tm++;
      if (m_tm == TMO-1) m_et = 1;
    end else m_tm = 0;
`endif
    if (ar_hs && !rl) m_rc++;
    else if (rl && !ar_hs) begin
      if (m_rc == 0) m_eu = 1; else m_rc--;
    end
    if (aw_hs && !bh) m_wc++;
    else if (bh && !aw_hs) begin
      if (m_wc == 0) m_eu = 1; else m_wc--;
    end
    if (w_hs) begin
      if (bus.s_wlast != (m_q[0] == 1)) m_ew = 1;
      m_q[0]--;
      if (m_q[0] == 0) void'(m_q.pop_front());
    end
    if (aw_hs) m_q.push_back(int'(bus.s_awlen) + 1);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rc = 0; m_wc = 0; m_tm = 0;
      m_ew = 0; m_eu = 0; m_et = 0; m_dr = 0;
      m_q.delete();
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    bit a_ar, a_aw, a_w;
    a_ar = (m_rc < MAX_R) && !drain_req;
    a_aw = (m_wc < MAX_W) && !drain_req;
    a_w  = (m_wb() != 0);
    chk("m_arvalid", bus.m_arvalid, bus.s_arvalid && a_ar);
    chk("s_arready", bus.s_arready, bus.m_arready && a_ar);
    chk("m_awvalid", bus.m_awvalid, bus.s_awvalid && a_aw);
    chk("s_awready", bus.s_awready, bus.m_awready && a_aw);
    chk("m_wvalid",  bus.m_wvalid,  bus.s_wvalid && a_w);
    chk("s_wready",  bus.s_wready,  bus.m_wready && a_w);
    chk("r_inflight", int'(r_inflight), m_rc);
    chk("w_inflight", int'(w_inflight), m_wc);
    chk("drained",    drained,     m_dr);
    chk("err_wlast",  err_wlast,   m_ew);
    chk("err_unexp",  err_unexp,   m_eu);
    chk("err_timeout", err_timeout, m_et);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.s_arvalid = 0; bus.s_awvalid = 0; bus.s_awlen = '0;
    bus.s_wvalid  = 0; bus.s_wlast   = 0;
    bus.m_arready = 1; bus.m_awready = 1; bus.m_wready = 1;
    bus.rvalid = 0; bus.rready = 1; bus.rlast = 1;
    bus.bvalid = 0; bus.bready = 1;
  endtask

  initial begin
    bit good;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_r_inflight", int'(r_inflight), 0);
    chk("rst_w_inflight", int'(w_inflight), 0);
    chk("rst_drained", drained, 0);
    chk("rst_err_wlast", err_wlast, 0);
    chk("rst_err_unexp", err_unexp, 0);
    chk("rst_err_timeout", err_timeout, 0);
    rst = 0;
    tick();

    // Read cap of 2: third AR waits for an RLAST
    bus.s_arvalid = 1; settle();
    chk("t1_arready_c0", bus.s_arready, 1);
    chk("t1_rinf_c0", int'(r_inflight), 0);
    tick(); settle();
    chk("t1_rinf_1", int'(r_inflight), 1);
    tick(); settle();
    chk("t1_rinf_2", int'(r_inflight), 2);
    chk("t1_arready_held", bus.s_arready, 0);
    chk("t1_marvalid_held", bus.m_arvalid, 0);
    tick(); settle();
    chk("t1_arready_held2", bus.s_arready, 0);
    bus.rvalid = 1;
    tick(); bus.rvalid = 0; settle();
    chk("t1_rinf_dec", int'(r_inflight), 1);
    chk("t1_arready_again", bus.s_arready, 1);
    tick(); bus.s_arvalid = 0; settle();
    chk("t1_rinf_back2", int'(r_inflight), 2);
    bus.rvalid = 1;
    repeat (2) tick();
    bus.rvalid = 0; settle();
    chk("t1_rinf_empty", int'(r_inflight), 0);

    // Same-cycle AR and RLAST
    bus.s_arvalid = 1;
    tick();
    bus.rvalid = 1; settle();
    chk("t3_arready", bus.s_arready, 1);
    tick(); bus.s_arvalid = 0; settle();
    chk("t3_rinf_same", int'(r_inflight), 1);
    chk("t3_no_unexp", err_unexp, 0);
    tick(); bus.rvalid = 0; settle();
    chk("t3_rinf_0", int'(r_inflight), 0);

    // W presented before AW
    bus.s_wvalid = 1; settle();
    chk("t2_w_blk_c0", bus.m_wvalid, 0);
    tick(); settle();
    chk("t2_w_blk_c1", bus.m_wvalid, 0);
    tick(); bus.s_awvalid = 1; bus.s_awlen = 8'd3; settle();
    chk("t2_w_blk_c2", bus.m_wvalid, 0);
    chk("t2_awready", bus.s_awready, 1);
    tick(); bus.s_awvalid = 0; settle();
    chk("t2_winf", int'(w_inflight), 1);
    for (int i = 0; i < 4; i++) begin
      bus.s_wlast = (i == 3); settle();
      chk("t2_beat_fwd", bus.m_wvalid, 1);
      tick();
    end
    bus.s_wlast = 0; settle();
    chk("t2_w_closed", bus.m_wvalid, 0);
    chk("t2_no_wlast_err", err_wlast, 0);
    bus.s_wvalid = 0; bus.bvalid = 1;
    tick(); bus.bvalid = 0; settle();
    chk("t2_winf_0", int'(w_inflight), 0);

    // Early WLAST on a two-beat burst
    bus.s_awvalid = 1; bus.s_awlen = 8'd1;
    tick(); bus.s_awvalid = 0;
    bus.s_wvalid = 1; bus.s_wlast = 1; settle();
    chk("t4_err_pre", err_wlast, 0);
    tick(); settle();
    chk("t4_err_set", err_wlast, 1);
    chk("t4_beat2_fwd", bus.m_wvalid, 1);
    tick(); bus.s_wvalid = 0; bus.s_wlast = 0; settle();
    chk("t4_err_sticky", err_wlast, 1);
    bus.bvalid = 1;
    tick(); bus.bvalid = 0;

    // Drain with one read outstanding
    bus.s_arvalid = 1;
    tick();
    drain_req = 1; settle();
    chk("t5_ar_blocked", bus.s_arready, 0);
    chk("t5_mar_blocked", bus.m_arvalid, 0);
    tick(); settle();
    chk("t5_not_drained", drained, 0);
    bus.rvalid = 1;
    tick(); bus.rvalid = 0; settle();
    chk("t5_drain_lag", drained, 0);
    tick(); settle();
    chk("t5_drained", drained, 1);
    drain_req = 0; bus.s_arvalid = 0;
    tick(); settle();
    chk("t5_undrained", drained, 0);

    // B with nothing outstanding
    bus.bvalid = 1;
    tick(); bus.bvalid = 0; settle();
    chk("unexp_b", err_unexp, 1);
    chk("unexp_winf", int'(w_inflight), 0);

    // Asynchronous reset mid-burst
    bus.s_awvalid = 1; bus.s_awlen = 8'd2;
    tick(); bus.s_awlen = 8'd1;
    tick(); bus.s_awvalid = 0; bus.s_wvalid = 1; settle();
    chk("t6_winf2", int'(w_inflight), 2);
    chk("t6_w_open", bus.m_wvalid, 1);
    #1 rst = 1; #1;
    chk("t6_rst_winf", int'(w_inflight), 0);
    chk("t6_rst_w_closed", bus.m_wvalid, 0);
    chk("t6_rst_err_wlast", err_wlast, 0);
    chk("t6_rst_err_unexp", err_unexp, 0);
    bus.s_wvalid = 0;
    tick(); tick(); rst = 0;

    // Held read with no progress
    bus.s_arvalid = 1;
    tick(); bus.s_arvalid = 0;
`ifdef DMA_INFLIGHT_TIMEOUT_EN
    repeat (TMO-2) tick();
    settle();
    chk("tmo_before", err_timeout, 0);
    tick(); settle();
    chk("tmo_fire", err_timeout, 1);
`else
    repeat (3*TMO) tick();
    settle();
    chk("tmo_off", err_timeout, 0);
`endif
    rst = 1;
    tick(); rst = 0;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) drain_req = !drain_req;
      bus.s_arvalid = $urandom_range(0, 1);
      bus.m_arready = ($urandom_range(0, 3) != 0);
      bus.s_awvalid = $urandom_range(0, 1);
      bus.s_awlen   = LW'($urandom_range(0, 3));
      bus.m_awready = ($urandom_range(0, 3) != 0);
      bus.s_wvalid  = $urandom_range(0, 1);
      bus.m_wready  = ($urandom_range(0, 3) != 0);
      good = (m_q.size() > 0) && (m_q[0] == 1);
      bus.s_wlast   = ($urandom_range(0, 15) == 0) ? !good : good;
      bus.rready    = ($urandom_range(0, 3) != 0);
      bus.rlast     = (m_rc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.rvalid    = (m_rc > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 63) == 0);
      bus.bready    = ($urandom_range(0, 3) != 0);
      if (m_wc > m_q.size())                  bus.bvalid = ($urandom_range(0, 2) == 0);
      else if (m_wc == 0 && !bus.s_awvalid)   bus.bvalid = ($urandom_range(0, 63) == 0);
      else                                    bus.bvalid = 0;
      tick();
    end

    rst = 0; drain_req = 0; idle();
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
